pdm_channel_sequencer: RTL
==========================

// Module: pdm_channel_sequencer
// PURPOSE
//  Sits downstream of the PDM-to-CIC adapter, which emits one CIC-input byte per mic with TLAST on the last mic.
//  Tracks the channel index of every beat and drops channels disabled by a runtime mask.
//  Tags each forwarded beat with its mic number in TUSER and regenerates TLAST on the last enabled channel.
//  Detects frame misalignment, resynchronises on it and counts it; feeds the shared CIC decimator.
// PARAMETERS
//  NUM_MICS   5                    mics per frame (>=2)
//  CIC_BITS   8                    sample width
//  CH_BITS    $clog2(NUM_MICS)     TUSER / channel index width
//  INIT_MASK  {NUM_MICS{1'b1}}     channel mask loaded at reset
// PORTS
//  clk                 in   1          clock
//  rst                 in   1          synchronous, active-high reset
//  s_axis_tvalid       in   1          input beat valid
//  s_axis_tready       out  1          input ready
//  s_axis_tdata        in   CIC_BITS   sample from adapter
//  s_axis_tlast        in   1          last mic of frame
//  m_axis_tvalid       out  1          output beat valid
//  m_axis_tready       in   1          downstream ready
//  m_axis_tdata        out  CIC_BITS   forwarded sample
//  m_axis_tlast        out  1          last enabled channel of frame
//  m_axis_tuser        out  CH_BITS    mic index of beat
//  cfg_mask            in   NUM_MICS   requested enable mask; bit i = mic i
//  cfg_mask_valid      in   1          one-cycle strobe: capture cfg_mask as pending
//  cfg_busy            out  1          pending mask not yet applied
//  stat_frames         out  16         frames seen (stats build only)
//  stat_sync_errs      out  8          misalignment count (stats build only)
// BEHAVIOUR
//  Reset:
//   - m_axis_tvalid=0, tdata/tlast/tuser=0, ch=0, active_mask=INIT_MASK.
//   - pending cleared, cfg_busy=0, stats=0.
//  Handshake:
//   - One output register; s_axis_tready = !m_axis_tvalid || m_axis_tready (also for dropped beats).
//   - accept = s_tvalid && s_tready.
//   - Forwarded beat appears on m_axis exactly 1 cycle after accept.
//   - Output held stable while tvalid && !tready.
//   - Full throughput: back-to-back accepts with tready=1.
//  Channel index:
//   - On accept, beat belongs to mic ch.
//   - ch_next = (s_tlast || ch==NUM_MICS-1) ? 0 : ch+1.
//  Drop / forward:
//   - Beat forwarded iff active_mask[ch]; otherwise consumed and m_axis_tvalid deasserts if nothing else pending.
//   - tuser = ch.
//   - tlast = active_mask[ch] && (ch==highest set bit of active_mask || s_tlast).
//  Masks:
//   - Mask==0: all beats consumed, nothing output, counters still run.
//  Sync error, when either holds:
//   - accepted s_tlast with ch!=NUM_MICS-1 (short frame): ch resets to 0.
//   - accepted beat at ch==NUM_MICS-1 without s_tlast (long frame): ch wraps to 0.
//   - Either case increments stat_sync_errs (saturates at 255). A short frame may lack an output TLAST only if its
//     final beat was a disabled channel; no extra beat is inserted.
//  Mask update:
//   - cfg_mask_valid latches cfg_mask into pending and sets cfg_busy; a later strobe overwrites pending.
//   - Apply pending to active_mask when (accept && ch_next==0) or (ch==0 && !accept); clear cfg_busy the same cycle.
//   - Never changes mid-frame.
//   - Strobe in the same cycle as apply: the new value becomes pending, and the old pending value is applied.
//  stat_frames: +1 on every accepted beat with ch_next==0; wraps at 2^16.
//  rst mid-frame: output beat discarded, ch=0, pending lost.
// CONFIGURATION
//  PDM_SEQ_STATS_EN defined:
//   - stat_frames / stat_sync_errs counters are built as above.
//  PDM_SEQ_STATS_EN undefined:
//   - stat ports are tied to 0 and no counter logic is built.
//   - Resync behaviour is unchanged.
// TESTING (NUM_MICS=5, CIC_BITS=8)
//  1. Mask 11111, 10 aligned frames, tready=1:
//     - 50 beats out, tuser 0..4 repeating.
//     - tlast on tuser=4 only; data bit-exact; 1-cycle latency.
//  2. cfg_mask=00101 strobed mid-frame at ch=2:
//     - Rest of frame uses 11111, cfg_busy=1 until frame end.
//     - Next frames output tuser 0,2 only, with tlast on 2.
//  3. Short frame (tlast at ch=2), then aligned frames:
//     - stat_sync_errs=1; next beat has tuser=0; later tlasts on tuser=4.
//  4. Long frame (no tlast at ch=4):
//     - stat_sync_errs increments; following beat tagged tuser=0.
//  5. Mask 00000:
//     - No m_axis_tvalid for 5 frames; s_tready stays 1; stat_frames +5.
//  6. 20% random tready drop + 80% random source stall, 1000 cycles:
//     - No beat lost, duplicated or altered while stalled.
//     - rst pulse mid-frame -> tvalid=0 next cycle, ch restarts at 0.

Source files
------------

// File: rtl/pdm_channel_sequencer.sv
// rtl/pdm_channel_sequencer.sv - per-mic channel tagging, masking and frame resync (stats under PDM_SEQ_STATS_EN)
module pdm_channel_sequencer #(
  parameter int                  NUM_MICS  = 5,
  parameter int                  CIC_BITS  = 8,
  parameter int                  CH_BITS   = $clog2(NUM_MICS),
  parameter logic [NUM_MICS-1:0] INIT_MASK = {NUM_MICS{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [CIC_BITS-1:0] s_axis_tdata,
  input  logic                s_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [CIC_BITS-1:0] m_axis_tdata,
  output logic                m_axis_tlast,
  output logic [CH_BITS-1:0]  m_axis_tuser,
  input  logic [NUM_MICS-1:0] cfg_mask,
  input  logic                cfg_mask_valid,
  output logic                cfg_busy,
  output logic [15:0]         stat_frames,
  output logic [7:0]          stat_sync_errs
);

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(NUM_MICS - 1);

  logic [CH_BITS-1:0]  ch;
  logic [CH_BITS-1:0]  ch_next;
  logic [CH_BITS-1:0]  hi_ch;
  logic [NUM_MICS-1:0] active_mask;
  logic [NUM_MICS-1:0] pending;
  logic                accept;
  logic                ch_en;
  logic                frame_end;
  logic                apply;

  // The output register may be reloaded whenever it is empty or being drained,
  // and dropped beats obey the same rule so the input never races ahead.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign ch_en         = active_mask[ch];
  assign ch_next       = (s_axis_tlast || ch == LAST_CH) ? '0 : ch + 1'b1;
  assign frame_end     = accept && (ch_next == '0);

  // Pending mask only lands on a frame boundary, so a frame never mixes masks.
  assign apply = cfg_busy && (frame_end || (ch == '0 && !accept));

  // Highest enabled mic closes the output frame.
  always_comb begin
    hi_ch = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      if (active_mask[i]) hi_ch = CH_BITS'(i);
    end
  end

  // Channel tracking, output register and mask bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch            <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      active_mask   <= INIT_MASK;
      pending       <= '0;
      cfg_busy      <= 1'b0;
    end else begin
      if (accept) ch <= ch_next;
      if (s_axis_tready) begin
        m_axis_tvalid <= accept && ch_en;
        if (accept && ch_en) begin
          m_axis_tdata <= s_axis_tdata;
          m_axis_tuser <= ch;
          m_axis_tlast <= (ch == hi_ch) || s_axis_tlast;
        end
      end
      if (apply) active_mask <= pending;
      if (cfg_mask_valid) pending <= cfg_mask;
      cfg_busy <= cfg_mask_valid || (cfg_busy && !apply);
    end
  end

`ifdef PDM_SEQ_STATS_EN
  logic sync_err;

  // Short frame (early tlast) or long frame (no tlast on the last mic).
  assign sync_err = accept && (s_axis_tlast != (ch == LAST_CH));

  // Frame counter wraps; sync error counter saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames    <= '0;
      stat_sync_errs <= '0;
    end else begin
      if (frame_end) stat_frames <= stat_frames + 16'd1;
      if (sync_err && stat_sync_errs != 8'hFF) stat_sync_errs <= stat_sync_errs + 8'd1;
    end
  end
`else
  assign stat_frames    = '0;
  assign stat_sync_errs = '0;
`endif

endmodule
